// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the DataPath: instruction/flag inputs and every
// DataPath control strobe the sequencer drives.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON;
    logic        stop;

    logic PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, in_port_out;
    logic MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable, HI_enable, LO_enable;
    logic IncPC, Read, RAM_write_enable, out_port_enable, con_in;
    logic Gra, Grb, Grc, R_in, R_out, BA_out;
    logic [4:0] alu_op;
    logic       run;

    modport master (
        input  IR, CON, stop,
        output PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, in_port_out,
        output MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable, HI_enable, LO_enable,
        output IncPC, Read, RAM_write_enable, out_port_enable, con_in,
        output Gra, Grb, Grc, R_in, R_out, BA_out, alu_op, run
    );

    modport slave (
        output IR, CON, stop,
        input  PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, in_port_out,
        input  MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable, HI_enable, LO_enable,
        input  IncPC, Read, RAM_write_enable, out_port_enable, con_in,
        input  Gra, Grb, Grc, R_in, R_out, BA_out, alu_op, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control FSM for the DataPath: fetch in T0-T2, decode IR[31:27], execute in T3-T7,
// repeat until halt/stop; only clr recovers from HALT.
//  state   | meaning
//  RESET   | held by clr, everything idle
//  T0..T2  | instruction fetch
//  T3..T7  | execute steps of the decoded opcode
//  HALT    | parked after halt opcode or stop, waits for clr
module control_sequencer #(
    parameter logic [4:0] OP_ADD  = 5'b00011,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic                Clock,
    input  logic                clr,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;

    state_t     state_q, state_d;
    logic [4:0] op;
    logic       unused_ir;

    assign op        = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    function automatic state_t last_step(input logic [4:0] code);
        state_t s;
        s = S_T3;
        case (code) inside
            OP_LD, OP_ST:             s = S_T7;
            OP_LDI:                   s = S_T5;
            [5'b00011:5'b01110]:      s = S_T5;
            OP_DIV, OP_MUL, OP_BR:    s = S_T6;
            OP_NEG, OP_NOT:           s = S_T4;
            default:                  s = S_T3;
        endcase
        return s;
    endfunction

    always_ff @(posedge Clock or posedge clr) begin
        if (clr) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                // stop only takes effect where the next state would have been T0
                if (state_q == S_T3 && op == OP_HALT) state_d = S_HALT;
                else if (state_q >= last_step(op))    state_d = bus.stop ? S_HALT : S_T0;
                else                                  state_d = state_t'(state_q + 4'd1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        bus.PC_out = 1'b0;      bus.MDR_out = 1'b0;     bus.ZLow_out = 1'b0;
        bus.ZHigh_out = 1'b0;   bus.HI_out = 1'b0;      bus.LO_out = 1'b0;
        bus.C_out = 1'b0;       bus.in_port_out = 1'b0;
        bus.MAR_enable = 1'b0;  bus.MDR_enable = 1'b0;  bus.IR_enable = 1'b0;
        bus.Y_enable = 1'b0;    bus.Z_enable = 1'b0;    bus.PC_enable = 1'b0;
        bus.HI_enable = 1'b0;   bus.LO_enable = 1'b0;
        bus.IncPC = 1'b0;       bus.Read = 1'b0;        bus.RAM_write_enable = 1'b0;
        bus.out_port_enable = 1'b0; bus.con_in = 1'b0;
        bus.Gra = 1'b0;         bus.Grb = 1'b0;         bus.Grc = 1'b0;
        bus.R_in = 1'b0;        bus.R_out = 1'b0;       bus.BA_out = 1'b0;
        bus.alu_op = 5'b00000;
        bus.run = (state_q != S_RESET) && (state_q != S_HALT);

        case (state_q)
            S_T0: begin bus.PC_out = 1'b1; bus.MAR_enable = 1'b1; end
            S_T1: begin
                bus.Read = 1'b1; bus.MDR_enable = 1'b1; bus.IncPC = 1'b1; bus.PC_enable = 1'b1;
            end
            S_T2: begin bus.MDR_out = 1'b1; bus.IR_enable = 1'b1; end
            S_T3: begin
                case (op) inside
                    OP_LD, OP_LDI, OP_ST: begin bus.Grb = 1'b1; bus.BA_out = 1'b1; bus.Y_enable = 1'b1; end
                    [5'b00011:5'b01110]:  begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
                    OP_DIV, OP_MUL:       begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
                    OP_NEG, OP_NOT: begin
                        bus.Grb = 1'b1; bus.R_out = 1'b1; bus.alu_op = op; bus.Z_enable = 1'b1;
                    end
                    OP_BR:   begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.con_in = 1'b1; end
                    OP_JR:   begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1; end
                    OP_IN:   begin bus.in_port_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    OP_OUT:  begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.out_port_enable = 1'b1; end
                    OP_MFHI: begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    OP_MFLO: begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op) inside
                    OP_LD, OP_LDI, OP_ST: begin bus.C_out = 1'b1; bus.alu_op = OP_ADD; bus.Z_enable = 1'b1; end
                    [5'b00011:5'b01011]: begin
                        bus.Grc = 1'b1; bus.R_out = 1'b1; bus.alu_op = op; bus.Z_enable = 1'b1;
                    end
                    [5'b01100:5'b01110]:  begin bus.C_out = 1'b1; bus.alu_op = op; bus.Z_enable = 1'b1; end
                    OP_DIV, OP_MUL: begin
                        bus.Grb = 1'b1; bus.R_out = 1'b1; bus.alu_op = op; bus.Z_enable = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    OP_BR:          begin bus.PC_out = 1'b1; bus.Y_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op) inside
                    OP_LDI, [5'b00011:5'b01110]: begin bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    OP_LD, OP_ST:   begin bus.ZLow_out = 1'b1; bus.MAR_enable = 1'b1; end
                    OP_DIV, OP_MUL: begin bus.ZLow_out = 1'b1; bus.LO_enable = 1'b1; end
                    OP_BR:          begin bus.C_out = 1'b1; bus.alu_op = OP_ADD; bus.Z_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op)
                    OP_LD:           begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
                    OP_ST:           begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.MDR_enable = 1'b1; end
                    OP_DIV, OP_MUL:  begin bus.ZHigh_out = 1'b1; bus.HI_enable = 1'b1; end
                    OP_BR:           begin bus.ZLow_out = 1'b1; bus.PC_enable = bus.CON; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op)
                    OP_LD:   begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    OP_ST:   bus.RAM_write_enable = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues hand-written per-cycle output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;
    typedef logic [32:0] vec_t;

    localparam int PC_OUT = 0,  MDR_OUT = 1,  ZLOW = 2,   ZHIGH = 3,  HI_OUT = 4,  LO_OUT = 5;
    localparam int C_OUT = 6,   INP = 7,      MAR_EN = 8, MDR_EN = 9, IR_EN = 10,  Y_EN = 11;
    localparam int Z_EN = 12,   PC_EN = 13,   HI_EN = 14, LO_EN = 15, INCPC = 16,  READ = 17;
    localparam int RAMW = 18,   OUTP = 19,    CONIN = 20, GRA = 21,   GRB = 22,    GRC = 23;
    localparam int RIN = 24,    ROUT = 25,    BAOUT = 26, RUN = 32;

    logic Clock;
    logic clr;
    control_sequencer_if bus ();

    control_sequencer dut (.Clock(Clock), .clr(clr), .bus(bus));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    vec_t dut_vec;
    assign dut_vec = {bus.run, bus.alu_op, bus.BA_out, bus.R_out, bus.R_in, bus.Grc, bus.Grb,
                      bus.Gra, bus.con_in, bus.out_port_enable, bus.RAM_write_enable, bus.Read,
                      bus.IncPC, bus.LO_enable, bus.HI_enable, bus.PC_enable, bus.Z_enable,
                      bus.Y_enable, bus.IR_enable, bus.MDR_enable, bus.MAR_enable, bus.in_port_out,
                      bus.C_out, bus.LO_out, bus.HI_out, bus.ZHigh_out, bus.ZLow_out, bus.MDR_out,
                      bus.PC_out};

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic vec_t B(input int i);
        vec_t v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic vec_t ALU(input logic [4:0] a);
        vec_t v;
        v = '0;
        v[31:27] = a;
        return v;
    endfunction

    function automatic vec_t R();
        return B(RUN);
    endfunction

    task automatic push(input vec_t v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string nm);
        push(R() | B(PC_OUT) | B(MAR_EN), {nm, "_T0"});
        push(R() | B(READ) | B(MDR_EN) | B(INCPC) | B(PC_EN), {nm, "_T1"});
        push(R() | B(MDR_OUT) | B(IR_EN), {nm, "_T2"});
    endtask

    // Whole instruction: fetch plus n execute steps, waits until the following T0.
    task automatic instr(input string nm, input logic [31:0] ir, input int n,
                         input vec_t s3, input vec_t s4, input vec_t s5, input vec_t s6, input vec_t s7);
        vec_t s[5];
        s[0] = s3; s[1] = s4; s[2] = s5; s[3] = s6; s[4] = s7;
        bus.IR = ir;
        fetch(nm);
        for (int k = 0; k < n; k++) push(R() | s[k], $sformatf("%s_T%0d", nm, k + 3));
        step(3 + n);
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            vec_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", t, dut_vec, e);
            end
            checks++;
            if ((bus.Read && bus.RAM_write_enable) ||
                ($countones({bus.PC_out, bus.MDR_out, bus.ZLow_out, bus.ZHigh_out, bus.HI_out,
                             bus.LO_out, bus.C_out, bus.in_port_out, bus.R_out, bus.BA_out}) > 1)) begin
                errors++;
                $display("FAIL %s_conflict got=%h exp=no_bus_or_mem_conflict", t, dut_vec);
            end
        end
    end

    initial begin
        clr = 1'b1;
        bus.IR = 32'h0;
        bus.CON = 1'b0;
        bus.stop = 1'b0;
        step(2);
        push('0, "reset_held");
        step(1);
        clr = 1'b0;
        push('0, "reset_release");
        step(1);

        instr("mflo", 32'hC9800000, 1, B(LO_OUT) | B(GRA) | B(RIN), '0, '0, '0, '0);
        instr("add", 32'h18918000, 3, B(GRB) | B(ROUT) | B(Y_EN),
              B(GRC) | B(ROUT) | ALU(5'b00011) | B(Z_EN), B(ZLOW) | B(GRA) | B(RIN), '0, '0);
        instr("ld", 32'h00800064, 5, B(GRB) | B(BAOUT) | B(Y_EN),
              B(C_OUT) | ALU(5'b00011) | B(Z_EN), B(ZLOW) | B(MAR_EN),
              B(READ) | B(MDR_EN), B(MDR_OUT) | B(GRA) | B(RIN));
        instr("st", 32'h10800064, 5, B(GRB) | B(BAOUT) | B(Y_EN),
              B(C_OUT) | ALU(5'b00011) | B(Z_EN), B(ZLOW) | B(MAR_EN),
              B(GRA) | B(ROUT) | B(MDR_EN), B(RAMW));
        bus.CON = 1'b0;
        instr("br_con0", 32'h98000000, 4, B(GRA) | B(ROUT) | B(CONIN), B(PC_OUT) | B(Y_EN),
              B(C_OUT) | ALU(5'b00011) | B(Z_EN), B(ZLOW), '0);
        bus.CON = 1'b1;
        instr("br_con1", 32'h98000000, 4, B(GRA) | B(ROUT) | B(CONIN), B(PC_OUT) | B(Y_EN),
              B(C_OUT) | ALU(5'b00011) | B(Z_EN), B(ZLOW) | B(PC_EN), '0);
        bus.CON = 1'b0;
        instr("neg", 32'h88000000, 2, B(GRB) | B(ROUT) | ALU(5'b10001) | B(Z_EN),
              B(ZLOW) | B(GRA) | B(RIN), '0, '0, '0);
        instr("addi", 32'h60000000, 3, B(GRB) | B(ROUT) | B(Y_EN),
              B(C_OUT) | ALU(5'b01100) | B(Z_EN), B(ZLOW) | B(GRA) | B(RIN), '0, '0);
        instr("ldi", 32'h08000000, 3, B(GRB) | B(BAOUT) | B(Y_EN),
              B(C_OUT) | ALU(5'b00011) | B(Z_EN), B(ZLOW) | B(GRA) | B(RIN), '0, '0);
        instr("div", 32'h78000000, 4, B(GRA) | B(ROUT) | B(Y_EN),
              B(GRB) | B(ROUT) | ALU(5'b01111) | B(Z_EN), B(ZLOW) | B(LO_EN),
              B(ZHIGH) | B(HI_EN), '0);
        instr("jr", 32'hA0000000, 1, B(GRA) | B(ROUT) | B(PC_EN), '0, '0, '0, '0);
        instr("in", 32'hB0000000, 1, B(INP) | B(GRA) | B(RIN), '0, '0, '0, '0);
        instr("out", 32'hB8000000, 1, B(GRA) | B(ROUT) | B(OUTP), '0, '0, '0, '0);
        instr("mfhi", 32'hC0000000, 1, B(HI_OUT) | B(GRA) | B(RIN), '0, '0, '0, '0);
        instr("nop", 32'hD0000000, 1, '0, '0, '0, '0, '0);
        instr("jal", 32'hA8000000, 1, '0, '0, '0, '0, '0);

        // clr in T5 of mul: outputs must drop in that same cycle
        bus.IR = 32'h80000000;
        fetch("mul");
        push(R() | B(GRA) | B(ROUT) | B(Y_EN), "mul_T3");
        push(R() | B(GRB) | B(ROUT) | ALU(5'b10000) | B(Z_EN), "mul_T4");
        step(5);
        clr = 1'b1;
        push('0, "mul_clr_T5");
        step(1);
        clr = 1'b0;
        push('0, "mul_clr_reset");
        step(1);

        // stop raised in T4 of add: add completes, then HALT
        bus.IR = 32'h18918000;
        fetch("add_stop");
        push(R() | B(GRB) | B(ROUT) | B(Y_EN), "add_stop_T3");
        step(4);
        bus.stop = 1'b1;
        push(R() | B(GRC) | B(ROUT) | ALU(5'b00011) | B(Z_EN), "add_stop_T4");
        push(R() | B(ZLOW) | B(GRA) | B(RIN), "add_stop_T5");
        push('0, "stop_halt0");
        push('0, "stop_halt1");
        step(4);
        bus.stop = 1'b0;
        push('0, "halt_after_stop_drop0");
        push('0, "halt_after_stop_drop1");
        step(2);
        clr = 1'b1;
        push('0, "halt_clr");
        step(1);
        clr = 1'b0;
        push('0, "halt_clr_release");
        step(1);

        bus.IR = 32'hD8000000;
        fetch("halt");
        push(R(), "halt_T3");
        push('0, "halt_parked0");
        push('0, "halt_parked1");
        step(6);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
